// File: rtl/contador_m_ud.sv
// Up/down modulo counter with runtime modulus, parallel load,
// one-shot mode and a registered wrap pulse.
module contador_m_ud #(
  parameter int N = 12,
  parameter int M = 3000
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         zera_s,
  input  logic         atualiza_m,
  input  logic [N-1:0] novo_m,
  input  logic         carrega,
  input  logic [N-1:0] D,
  input  logic         conta,
  input  logic         desce,
  input  logic         modo,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         estouro,
  output logic         parado
);

  typedef enum logic {
    CONTANDO = 1'b0,
    PARADO   = 1'b1
  } estado_t;

  localparam logic [N-1:0] M_RST = N'(M);
  localparam logic [N-1:0] UM    = N'(1);
  localparam logic [N-1:0] DOIS  = N'(2);

  estado_t      st_q, st_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] mod_q, mod_d;
  logic         est_q, est_d;

  logic [N-1:0] mod_m1;
  logic [N-1:0] term;
  logic [N-1:0] meio_val;
  logic [N-1:0] d_clamp;
  logic         at_term;

  assign mod_m1   = mod_q - UM;
  assign term     = desce ? '0 : mod_m1;
  assign at_term  = (q_q == term);
  assign meio_val = (mod_q >> 1) - UM;
  assign d_clamp  = (D > mod_m1) ? mod_m1 : D;

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      st_q  <= CONTANDO;
      q_q   <= '0;
      mod_q <= M_RST;
      est_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      q_q   <= q_d;
      mod_q <= mod_d;
      est_q <= est_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    q_d   = q_q;
    mod_d = mod_q;
    est_d = 1'b0;
    if (zera_s) begin
      q_d  = '0;
      st_d = CONTANDO;
    end else if (atualiza_m) begin
      // a zero modulus is rejected but still clears the count
      if (novo_m != '0) mod_d = novo_m;
      q_d  = '0;
      st_d = CONTANDO;
    end else if (carrega) begin
      q_d  = d_clamp;
      st_d = CONTANDO;
    end else if (conta && st_q == CONTANDO) begin
      if (at_term) begin
        est_d = 1'b1;
        if (modo) st_d = PARADO;
        else      q_d  = desce ? mod_m1 : '0;
      end else begin
        q_d = desce ? q_q - UM : q_q + UM;
      end
    end
  end

  assign Q       = q_q;
  assign fim     = at_term;
  assign meio    = (mod_q >= DOIS) && (q_q == meio_val);
  assign estouro = est_q;
  assign parado  = (st_q == PARADO);

endmodule

// File: tb/tb_contador_m_ud.sv
// Directed plus randomized bench for contador_m_ud against
// an integer reference model of the counting rules.
module tb_contador_m_ud;

  localparam int N = 4;
  localparam int M = 10;

  logic         clock = 1'b0;
  logic         zera_as_n;
  logic         zera_s;
  logic         atualiza_m;
  logic [N-1:0] novo_m;
  logic         carrega;
  logic [N-1:0] D;
  logic         conta;
  logic         desce;
  logic         modo;
  logic [N-1:0] Q;
  logic         fim;
  logic         meio;
  logic         estouro;
  logic         parado;

  int mq, mmod, mest, mpar;
  int checks = 0;
  int failures = 0;

  contador_m_ud #(.N(N), .M(M)) dut (
    .clock      (clock),
    .zera_as_n  (zera_as_n),
    .zera_s     (zera_s),
    .atualiza_m (atualiza_m),
    .novo_m     (novo_m),
    .carrega    (carrega),
    .D          (D),
    .conta      (conta),
    .desce      (desce),
    .modo       (modo),
    .Q          (Q),
    .fim        (fim),
    .meio       (meio),
    .estouro    (estouro),
    .parado     (parado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq = 0;
    mmod = M;
    mest = 0;
    mpar = 0;
  endtask

  task automatic model_edge();
    int term;
    term = desce ? 0 : mmod - 1;
    mest = 0;
    if (zera_s) begin
      mq = 0;
      mpar = 0;
    end else if (atualiza_m) begin
      if (novo_m != 0) mmod = int'(novo_m);
      mq = 0;
      mpar = 0;
    end else if (carrega) begin
      mq = (int'(D) > mmod - 1) ? mmod - 1 : int'(D);
      mpar = 0;
    end else if (conta && mpar == 0) begin
      mest = (mq == term) ? 1 : 0;
      if (mest == 1 && modo) mpar = 1;
      else mq = (mq + (desce ? mmod - 1 : 1)) % mmod;
    end
  endtask

  task automatic check_all(input string tag);
    int efim, emeio;
    efim  = (mq == (desce ? 0 : mmod - 1)) ? 1 : 0;
    emeio = (mmod >= 2 && mq == mmod / 2 - 1) ? 1 : 0;
    chk({tag, ".Q"}, 32'(Q), mq);
    chk({tag, ".fim"}, 32'(fim), efim);
    chk({tag, ".meio"}, 32'(meio), emeio);
    chk({tag, ".estouro"}, 32'(estouro), mest);
    chk({tag, ".parado"}, 32'(parado), mpar);
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    zera_s = 0;
    atualiza_m = 0;
    carrega = 0;
    conta = 0;
  endtask

  initial begin
    zera_as_n = 0;
    idle();
    novo_m = '0;
    D = '0;
    desce = 0;
    modo = 0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clock);
    zera_as_n = 1;

    // cyclic up: 1..9,0,1,2
    conta = 1;
    repeat (12) tick("up");
    chk("up_end", 32'(Q), 2);

    // fim follows desce with no clock edge
    idle();
    zera_s = 1;
    tick("clr");
    zera_s = 0;
    desce = 1;
    #1;
    check_all("fim_comb");

    // cyclic down: 9,8,...,0,9,8
    conta = 1;
    repeat (12) tick("down");
    chk("down_end", 32'(Q), 8);

    // one-shot from 7
    idle();
    desce = 0;
    carrega = 1;
    D = 4'd7;
    tick("load7");
    carrega = 0;
    modo = 1;
    conta = 1;
    repeat (4) tick("oneshot");
    chk("oneshot_q", 32'(Q), 9);
    chk("oneshot_par", 32'(parado), 1);
    carrega = 1;
    D = 4'd3;
    tick("release");
    chk("release_q", 32'(Q), 3);

    // modulus change while Q=8
    idle();
    modo = 0;
    carrega = 1;
    D = 4'd8;
    tick("load8");
    carrega = 0;
    atualiza_m = 1;
    novo_m = 4'd5;
    tick("mod5");
    atualiza_m = 0;
    conta = 1;
    repeat (7) tick("mod5_up");
    conta = 0;
    atualiza_m = 1;
    novo_m = 4'd0;
    tick("mod0");
    atualiza_m = 0;
    carrega = 1;
    D = 4'd12;
    tick("clamp");
    chk("clamp_q", 32'(Q), 4);

    // simultaneous events
    zera_s = 1;
    atualiza_m = 1;
    novo_m = 4'd6;
    carrega = 1;
    D = 4'd2;
    conta = 1;
    tick("prio_all");
    zera_s = 0;
    atualiza_m = 0;
    tick("prio_load");
    chk("prio_q", 32'(Q), 2);
    carrega = 0;
    repeat (6) tick("prio_cnt");

    // async reset while frozen and mid-pulse
    modo = 1;
    carrega = 1;
    D = 4'd3;
    tick("a_load");
    carrega = 0;
    tick("a_cnt");
    tick("a_term");
    chk("a_pulse", 32'(estouro), 1);
    #2;
    zera_as_n = 0;
    model_reset();
    #1;
    check_all("async");
    chk("async_par", 32'(parado), 0);
    #2;
    zera_as_n = 1;
    modo = 0;
    repeat (11) tick("after_rst");
    chk("after_rst_q", 32'(Q), 1);

    // randomized traffic
    repeat (500) begin
      zera_s     = ($urandom_range(99) < 3);
      atualiza_m = ($urandom_range(99) < 4);
      novo_m     = N'($urandom_range(15));
      carrega    = ($urandom_range(99) < 8);
      D          = N'($urandom_range(15));
      conta      = ($urandom_range(99) < 80);
      if ($urandom_range(99) < 10) desce = ~desce;
      if ($urandom_range(99) < 8) modo = ~modo;
      if ($urandom_range(99) < 2) begin
        zera_as_n = 0;
        model_reset();
        #1;
        check_all("rnd_async");
        zera_as_n = 1;
      end
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
